coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
- Front-end feeder for `vending_machine`.
- Takes raw coin-insert events from the coin sensor, buffers them in a small FIFO, and replays them as the one-cycle-per-coin `coin` code stream the vending machine consumes.
- Keeps a shadow credit, pauses the coin stream while a sale is pending, and closes each sale on the vending machine's `can_despatch` pulse.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- GAP, 1: idle cycles (coin=00) driven after each issued coin; 0 allowed.
- PRICE, 15: sale price in rupees; multiple of 5, maximum 30.
- HOLD_TIMEOUT, 8: cycles to wait for `can_despatch` before aborting a sale.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ins_valid  in  1  sensor reports a coin this cycle.
- ins_type  in  2  01=5 rupee, 10=10 rupee; 00 and 11 are invalid.
- ins_ready  out  1  FIFO not full.
- coin  out  2  coin code to vending_machine; 00 when no coin.
- can_despatch  in  1  despatch pulse from vending_machine.
- reject  out  1  one-cycle pulse: inserted coin returned to user.
- credit  out  6  shadow credit in rupees.
- vend_count  out  8  completed sales; wraps 255->0.
- timeout_err  out  1  sticky flag, set on a HOLD timeout.

Behaviour:
- Reset is asynchronous, active-high. All outputs registered. Reset values:
  - coin=00, reject=0, credit=0, vend_count=0, timeout_err=0, ins_ready=1.
  - FIFO emptied; FSM in IDLE.
- Push rule:
  - Push occurs when ins_valid=1 and ins_type is 01/10 and the FIFO is not full.
  - Otherwise ins_valid=1 gives reject=1 on the next cycle and no push.
  - Push and pop in the same cycle are both honoured.
  - ins_ready reflects occupancy before that cycle's push/pop.
- FSM states: IDLE, ISSUE, GAP, HOLD.
- IDLE:
  - coin=00.
  - FIFO non-empty -> pop -> ISSUE.
- ISSUE (exactly one cycle):
  - coin = popped code; credit += 5 or 10.
  - Next state: GAP if GAP>0 and the new credit < PRICE.
  - HOLD if the new credit >= PRICE.
  - Otherwise IDLE, or pop and stay in ISSUE if the FIFO is non-empty (back-to-back coins).
- GAP:
  - coin=00 for exactly GAP cycles, then same exit as IDLE.
- HOLD:
  - coin=00; the FIFO keeps accepting but does not pop.
  - can_despatch=1 sampled -> credit -= PRICE (remainder carried), vend_count++, -> IDLE.
  - No can_despatch within HOLD_TIMEOUT cycles -> timeout_err=1, credit=0, -> IDLE.
- can_despatch=1 outside HOLD is ignored.
- Latency: a coin pushed at edge k into an empty FIFO in IDLE appears on coin after edge k+2 and holds for one cycle.
- Credit width: 6 bits. Maximum credit is PRICE-5+10 ≤ 35, so it never overflows.
- Simultaneous events:
  - A push while in HOLD is buffered.
  - A push while full is rejected even if a pop occurs the same cycle.
- Reset mid-sale: credit and the FIFO contents are lost; no despatch is counted.

Optional Feature:
- Macro: COIN_CHANGE_EN.
- Defined:
  - Adds output change (6 bits).
  - On a HOLD exit by despatch, change = credit-PRICE for one cycle, and credit is cleared to 0 instead of carried.
  - change=0 at reset and in all other cycles.
- Undefined:
  - No change port.
  - Remainder credit is carried into the next sale.

Test Plan:
- Reset with rst=1 for 3 cycles, then release -> coin=00, credit=0, vend_count=0, ins_ready=1, reject=0.
- GAP=1, insert 5,10 on consecutive cycles:
  - coin=01 for one cycle, then 00, then 10.
  - credit 5 then 15; FSM enters HOLD.
  - can_despatch pulse -> vend_count=1, credit=0.
- Insert 10,10, then despatch:
  - Without COIN_CHANGE_EN: credit=5 carried.
  - With COIN_CHANGE_EN: change=5 for one cycle, credit=0.
- DEPTH=4, sale held in HOLD, insert 5 coins back-to-back:
  - ins_ready drops after the 4th.
  - 5th coin gives reject=1; no 6th entry appears.
- Insert ins_type=11 and 00 -> reject=1 each; credit unchanged; coin stays 00.
- Reach HOLD, never assert can_despatch:
  - After 8 cycles timeout_err=1, credit=0, vend_count unchanged.
  - The buffered coin then issues.
  - Assert rst mid-HOLD -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: front end for vending_machine.
//
// Raw coin-insert events from the coin sensor are buffered in a small FIFO
// and replayed as a one-cycle-per-coin `coin` code stream. A shadow credit
// is kept. The stream pauses while a sale is pending (HOLD), and each sale
// closes on the vending machine's `can_despatch` pulse or on a timeout.
//
// Parameters:
//   DEPTH        FIFO entries (power of 2, >= 2)
//   GAP          idle cycles driven after each issued coin (0 allowed)
//   PRICE        sale price in rupees (multiple of 5, <= 30)
//   HOLD_TIMEOUT cycles to wait in HOLD for can_despatch
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   ins_valid     sensor reports a coin this cycle
//   ins_type      01 = 5 rupee, 10 = 10 rupee, 00/11 invalid
//   ins_ready     FIFO not full (occupancy before this cycle's push/pop)
//   coin          coin code to vending_machine, 00 when no coin
//   can_despatch  despatch pulse from vending_machine (honoured only in HOLD)
//   reject        one-cycle pulse: the inserted coin is returned to the user
//   credit        shadow credit in rupees
//   vend_count    completed sales, wraps 255 -> 0
//   timeout_err   sticky flag, set when HOLD times out
//   change        (COIN_CHANGE_EN only) one-cycle change amount on despatch
//
// Optional feature macro: COIN_CHANGE_EN. When defined, a despatch clears the
// credit and reports the remainder on `change`. Otherwise the remainder is
// carried into the next sale.
//
// Sensor handshake: a coin is taken on any cycle where ins_valid=1, ins_type
// is a legal code and the FIFO is not full at the start of that cycle. Any
// other ins_valid=1 cycle is refused and answered by a reject pulse on the
// following cycle. ins_ready is advisory: it shows the same "not full"
// condition, registered.
module coin_acceptor #(
  parameter int DEPTH        = 4,
  parameter int GAP          = 1,
  parameter int PRICE        = 15,
  parameter int HOLD_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ins_valid,
  input  logic [1:0] ins_type,
  output logic       ins_ready,
  output logic [1:0] coin,
  input  logic       can_despatch,
  output logic       reject,
  output logic [5:0] credit,
  output logic [7:0] vend_count,
  output logic       timeout_err
`ifdef COIN_CHANGE_EN
  ,
  output logic [5:0] change
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP + 1) + 1;
  localparam int HW = $clog2(HOLD_TIMEOUT + 1) + 1;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
  localparam logic [5:0]    PRICE_V   = 6'(PRICE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    fifo_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    state_q, state_d;
  logic [1:0]    issue_code_q, issue_code_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic [1:0]    coin_q, coin_d;
  logic          reject_q, reject_d;
  logic          ins_ready_q, ins_ready_d;
  logic [5:0]    credit_q, credit_d;
  logic [7:0]    vend_count_q, vend_count_d;
  logic          timeout_err_q, timeout_err_d;
`ifdef COIN_CHANGE_EN
  logic [5:0]    change_q, change_d;
`endif

  logic          fifo_empty, fifo_full, type_ok, push, pop;
  logic [5:0]    coin_val, credit_new;

  // FIFO bookkeeping and push decision
  always_comb begin
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == FULL_CNT);
    type_ok     = (ins_type == 2'b01) || (ins_type == 2'b10);
    // Full is judged before any same-cycle pop, so a pop never frees room
    // for a coin arriving in the same cycle.
    push        = ins_valid && type_ok && !fifo_full;
    reject_d    = ins_valid && !push;
    coin_val    = (issue_code_q == 2'b01) ? 6'd5 : 6'd10;
    credit_new  = credit_q + coin_val;
  end

  // Sale FSM. The coin popped on entry to ISSUE is presented on `coin`
  // during the cycle after ISSUE, together with the updated credit.
  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    pop           = 1'b0;
    coin_d        = 2'b00;
    credit_d      = credit_q;
    vend_count_d  = vend_count_q;
    timeout_err_d = timeout_err_q;
`ifdef COIN_CHANGE_EN
    change_d      = 6'd0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        coin_d   = issue_code_q;
        credit_d = credit_new;
        if (credit_new >= PRICE_V) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end else if (GAP > 0) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin // S_HOLD: FIFO still fills, nothing pops
        if (can_despatch) begin
          vend_count_d = vend_count_q + 8'd1;
`ifdef COIN_CHANGE_EN
          change_d     = credit_q - PRICE_V;
          credit_d     = 6'd0;
`else
          credit_d     = credit_q - PRICE_V;
`endif
          state_d      = S_IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          timeout_err_d = 1'b1;
          credit_d      = 6'd0;
          state_d       = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
    endcase

    issue_code_d = pop ? fifo_mem_q[rd_ptr_q] : issue_code_q;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    ins_ready_d  = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= ins_type;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      issue_code_q  <= 2'b00;
      gap_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      coin_q        <= 2'b00;
      reject_q      <= 1'b0;
      ins_ready_q   <= 1'b1;
      credit_q      <= 6'd0;
      vend_count_q  <= 8'd0;
      timeout_err_q <= 1'b0;
`ifdef COIN_CHANGE_EN
      change_q      <= 6'd0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      issue_code_q  <= issue_code_d;
      gap_cnt_q     <= gap_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      coin_q        <= coin_d;
      reject_q      <= reject_d;
      ins_ready_q   <= ins_ready_d;
      credit_q      <= credit_d;
      vend_count_q  <= vend_count_d;
      timeout_err_q <= timeout_err_d;
`ifdef COIN_CHANGE_EN
      change_q      <= change_d;
`endif
    end
  end

  assign coin        = coin_q;
  assign reject      = reject_q;
  assign ins_ready   = ins_ready_q;
  assign credit      = credit_q;
  assign vend_count  = vend_count_q;
  assign timeout_err = timeout_err_q;
`ifdef COIN_CHANGE_EN
  assign change      = change_q;
`endif

endmodule
